// File: rtl/bin_counter_checker_pkg.sv
// Shared definitions for the binary counter checker: FSM states, error-kind bit
// positions and the counter next-value function, which stimulus code can reuse.
package bin_counter_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b01,
    HALT  = 2'b10
  } state_t;

  localparam int unsigned KIND_Q    = 0;
  localparam int unsigned KIND_TICK = 1;

  localparam int unsigned BN_W = 32;

  // Operands are zero-extended to BN_W bits. Callers truncate the result to
  // the counter width, which gives the mod-2^N wrap in both directions.
  function automatic logic [BN_W-1:0] bin_next(
    input logic            syn_clr,
    input logic            load,
    input logic            en,
    input logic            up,
    input logic [BN_W-1:0] d,
    input logic [BN_W-1:0] x
  );
    if (syn_clr)         return '0;
    else if (load)       return d;
    else if (en && up)   return x + 32'd1;
    else if (en && !up)  return x - 32'd1;
    else                 return x;
  endfunction

endpackage

// File: rtl/bin_counter_checker_if.sv
// Control and status bus of the universal binary counter, as seen by the checker.
interface bin_counter_checker_if #(
  parameter int unsigned N = 3
);
  logic         syn_clr;
  logic         load;
  logic         en;
  logic         up;
  logic [N-1:0] d;
  logic [N-1:0] q;
  logic         max_tick;
  logic         min_tick;

  modport master (output syn_clr, load, en, up, d, q, max_tick, min_tick);
  modport slave  (input  syn_clr, load, en, up, d, q, max_tick, min_tick);
endinterface

// File: rtl/bin_counter_checker_sat_counter.sv
// CW-bit saturating event counter with synchronous clear taking priority.
module sat_counter #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != '1))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/bin_counter_checker.sv
// Reference-model checker for the universal binary counter: predicts q from the
// observed controls and reports value and tick mismatches with statistics.
module bin_counter_checker
  import bin_counter_checker_pkg::*;
#(
  parameter int unsigned N           = 3,
  parameter int unsigned CW          = 8,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        chk_en,
  input  logic                        clr_stats,
  bin_counter_checker_if.slave        bus,
  output logic                        err,
  output logic                        err_sticky,
  output logic [CW-1:0]               err_cnt,
  output logic [CW-1:0]               chk_cnt,
  output logic [N-1:0]                first_exp,
  output logic [N-1:0]                first_act,
  output logic [1:0]                  first_kind,
  output logic                        busy
);

  state_t       state_q;
  logic [N-1:0] ref_q;
  logic         err_q, sticky_q;
  logic [N-1:0] fexp_q, fact_q;
  logic [1:0]   fkind_q;

  logic [1:0]   kind_d;
  logic         mism_d, cmp_d;
  logic [N-1:0] pred_obs_d, pred_ref_d;

  // Ticks are judged against observed q, so a single fault shows as one kind.
  always_comb begin
    kind_d           = '0;
    kind_d[KIND_Q]   = (bus.q != ref_q);
    kind_d[KIND_TICK] = (bus.max_tick != (bus.q == '1)) ||
                        (bus.min_tick != (bus.q == '0));
    mism_d           = |kind_d;
    cmp_d            = (state_q == CHECK) && !clr_stats;
    pred_obs_d       = N'(bin_next(bus.syn_clr, bus.load, bus.en, bus.up,
                                   BN_W'(bus.d), BN_W'(bus.q)));
    pred_ref_d       = N'(bin_next(bus.syn_clr, bus.load, bus.en, bus.up,
                                   BN_W'(bus.d), BN_W'(ref_q)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ref_q    <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      fexp_q   <= '0;
      fact_q   <= '0;
      fkind_q  <= '0;
    end else if (clr_stats) begin
      state_q  <= IDLE;
      ref_q    <= pred_obs_d;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      fexp_q   <= '0;
      fact_q   <= '0;
      fkind_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          err_q <= 1'b0;
          ref_q <= pred_obs_d;
          if (chk_en) state_q <= CHECK;
        end
        CHECK: begin
          err_q <= mism_d;
          if (mism_d) begin
            // Resync to the observed value so one fault does not cascade.
            ref_q <= pred_obs_d;
            if (!sticky_q) begin
              sticky_q <= 1'b1;
              fexp_q   <= ref_q;
              fact_q   <= bus.q;
              fkind_q  <= kind_d;
            end
          end else begin
            ref_q <= pred_ref_d;
          end
          if (!chk_en)                    state_q <= IDLE;
          else if (mism_d && STOP_ON_ERR) state_q <= HALT;
        end
        HALT: begin
          err_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.CW(CW)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (clr_stats),
    .inc_i (cmp_d && mism_d),
    .cnt_o (err_cnt)
  );

  sat_counter #(.CW(CW)) u_chk_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (clr_stats),
    .inc_i (cmp_d),
    .cnt_o (chk_cnt)
  );

  assign err        = err_q;
  assign err_sticky = sticky_q;
  assign first_exp  = fexp_q;
  assign first_act  = fact_q;
  assign first_kind = fkind_q;
  assign busy       = (state_q == CHECK);

endmodule

// File: tb/tb_bin_counter_checker.sv
// Directed bench: a simple counter model with fault injection drives two checkers
// (resync and stop-on-error) whose status is compared with hand-computed values.
module tb_bin_counter_checker;

  localparam int unsigned N  = 3;
  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  logic reset, chk_en, clr_stats;
  always #5 clk = ~clk;

  bin_counter_checker_if #(.N(N)) bus ();

  logic          err        [2];
  logic          err_sticky [2];
  logic [CW-1:0] err_cnt    [2];
  logic [CW-1:0] chk_cnt    [2];
  logic [N-1:0]  first_exp  [2];
  logic [N-1:0]  first_act  [2];
  logic [1:0]    first_kind [2];
  logic          busy       [2];

  bin_counter_checker #(.N(N), .CW(CW), .STOP_ON_ERR(1'b0)) dut0 (
    .clk(clk), .reset(reset), .chk_en(chk_en), .clr_stats(clr_stats), .bus(bus),
    .err(err[0]), .err_sticky(err_sticky[0]), .err_cnt(err_cnt[0]), .chk_cnt(chk_cnt[0]),
    .first_exp(first_exp[0]), .first_act(first_act[0]), .first_kind(first_kind[0]),
    .busy(busy[0]));

  bin_counter_checker #(.N(N), .CW(CW), .STOP_ON_ERR(1'b1)) dut1 (
    .clk(clk), .reset(reset), .chk_en(chk_en), .clr_stats(clr_stats), .bus(bus),
    .err(err[1]), .err_sticky(err_sticky[1]), .err_cnt(err_cnt[1]), .chk_cnt(chk_cnt[1]),
    .first_exp(first_exp[1]), .first_act(first_act[1]), .first_kind(first_kind[1]),
    .busy(busy[1]));

  // Counter model; its next value follows the displayed q, so an injected
  // upset persists like a real register fault.
  logic [2:0] cnt, qv, fq_val;
  logic       fq_en, fmax0;

  function automatic logic [2:0] mnext(input logic sc, ld, e, u,
                                       input logic [2:0] dd, x);
    if (sc)         return 3'd0;
    if (ld)         return dd;
    if (e && u)     return x + 3'd1;
    if (e)          return x - 3'd1;
    return x;
  endfunction

  assign qv           = fq_en ? fq_val : cnt;
  assign bus.q        = qv;
  assign bus.max_tick = fmax0 ? 1'b0 : (qv == 3'd7);
  assign bus.min_tick = (qv == 3'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= 3'd0;
    else       cnt <= mnext(bus.syn_clr, bus.load, bus.en, bus.up, bus.d, qv);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_dut(input int i, input logic e, input int ec, input int cc, input logic b);
    check($sformatf("dut%0d err", i),     32'(err[i]),     32'(e));
    check($sformatf("dut%0d err_cnt", i), 32'(err_cnt[i]), ec);
    check($sformatf("dut%0d chk_cnt", i), 32'(chk_cnt[i]), cc);
    check($sformatf("dut%0d busy", i),    32'(busy[i]),    32'(b));
  endtask

  task automatic chk_cap(input int i, input logic s, input int fe, input int fa, input int fk);
    check($sformatf("dut%0d err_sticky", i), 32'(err_sticky[i]), 32'(s));
    check($sformatf("dut%0d first_exp", i),  32'(first_exp[i]),  fe);
    check($sformatf("dut%0d first_act", i),  32'(first_act[i]),  fa);
    check($sformatf("dut%0d first_kind", i), 32'(first_kind[i]), fk);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ctrl(input logic sc, ld, e, u, input logic [2:0] dd);
    bus.syn_clr = sc; bus.load = ld; bus.en = e; bus.up = u; bus.d = dd;
  endtask

  typedef struct {
    logic       sc, ld, e, u;
    logic [2:0] dd;
    int         exp_chk;
  } vec_t;

  vec_t vecs[21];

  initial begin
    // Counting up through the wrap, priority clear, load, and down through 0->7.
    for (int i = 0; i <= 10; i++) vecs[i] = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd0, i};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 11};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 12};
    for (int i = 13; i <= 19; i++) vecs[i] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, i};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 20};

    reset = 1'b1; chk_en = 1'b0; clr_stats = 1'b0;
    fq_en = 1'b0; fq_val = 3'd0; fmax0 = 1'b0;
    ctrl(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk_dut(i, 1'b0, 0, 0, 1'b0);
      chk_cap(i, 1'b0, 0, 0, 0);
    end
    reset = 1'b0;
    chk_en = 1'b1;

    for (int v = 0; v < 21; v++) begin
      ctrl(vecs[v].sc, vecs[v].ld, vecs[v].e, vecs[v].u, vecs[v].dd);
      step();
      for (int i = 0; i < 2; i++) chk_dut(i, 1'b0, 0, vecs[v].exp_chk, 1'b1);
    end

    // q upset to 3 while the expected value is 2.
    ctrl(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    fq_en = 1'b1; fq_val = 3'd3;
    step();
    chk_dut(0, 1'b1, 1, 21, 1'b1);
    chk_dut(1, 1'b1, 1, 21, 1'b0);
    for (int i = 0; i < 2; i++) chk_cap(i, 1'b1, 2, 3, 1);

    fq_en = 1'b0;
    step();
    chk_dut(0, 1'b0, 1, 22, 1'b1);
    chk_dut(1, 1'b0, 1, 21, 1'b0);

    ctrl(1'b0, 1'b1, 1'b0, 1'b0, 3'd7);
    step();
    chk_dut(0, 1'b0, 1, 23, 1'b1);
    chk_dut(1, 1'b0, 1, 21, 1'b0);

    // Missing max_tick at q=7: counted, but capture keeps the first error.
    ctrl(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    fmax0 = 1'b1;
    step();
    chk_dut(0, 1'b1, 2, 24, 1'b1);
    chk_dut(1, 1'b0, 1, 21, 1'b0);
    for (int i = 0; i < 2; i++) chk_cap(i, 1'b1, 2, 3, 1);

    fmax0 = 1'b0; clr_stats = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      chk_dut(i, 1'b0, 0, 0, 1'b0);
      chk_cap(i, 1'b0, 0, 0, 0);
    end

    clr_stats = 1'b0;
    step();
    for (int i = 0; i < 2; i++) chk_dut(i, 1'b0, 0, 0, 1'b1);

    fmax0 = 1'b1;
    step();
    chk_dut(0, 1'b1, 1, 1, 1'b1);
    chk_dut(1, 1'b1, 1, 1, 1'b0);
    for (int i = 0; i < 2; i++) chk_cap(i, 1'b1, 7, 7, 2);

    // Further bad q: counted by the resync checker, ignored by the halted one.
    fmax0 = 1'b0; fq_en = 1'b1; fq_val = 3'd1;
    step();
    chk_dut(0, 1'b1, 2, 2, 1'b1);
    chk_dut(1, 1'b0, 1, 1, 1'b0);
    for (int i = 0; i < 2; i++) chk_cap(i, 1'b1, 7, 7, 2);

    fq_en = 1'b0;
    ctrl(1'b0, 1'b1, 1'b0, 1'b0, 3'd4);
    step();
    chk_dut(0, 1'b0, 2, 3, 1'b1);
    chk_dut(1, 1'b0, 1, 1, 1'b0);

    // Reset mid-count at q=4.
    ctrl(1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk_dut(i, 1'b0, 0, 0, 1'b0);
      chk_cap(i, 1'b0, 0, 0, 0);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    for (int i = 0; i < 2; i++) chk_dut(i, 1'b0, 0, 0, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      step();
      for (int i = 0; i < 2; i++) chk_dut(i, 1'b0, 0, k, 1'b1);
    end
    for (int i = 0; i < 2; i++) chk_cap(i, 1'b0, 0, 0, 0);

    // Compared-cycle count saturates at 2^CW-1.
    repeat (260) step();
    for (int i = 0; i < 2; i++) chk_dut(i, 1'b0, 0, 255, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bin_counter_checker.md
Name: bin_counter_checker

Overview:
- Synthesizable checker for the universal binary counter.
- It observes the same control bus that the stimulus generator drives: syn_clr, load, en, up and d.
- It also observes the counter's outputs: q, max_tick and min_tick.
- It runs an independent reference model and flags mismatches, so the counter can be self-checked on the board and in simulation without a behavioural monitor.

Parameters:
- N, 3, counter width; must match the counter under check.
- CW, 8, width of the error and check counters.
- STOP_ON_ERR, 0, 1 halts checking on the first error; 0 resyncs and continues.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- chk_en  in  1  arm the checker; 0 means track only.
- clr_stats  in  1  synchronous clear of statistics and the HALT state.
- syn_clr  in  1  observed counter control.
- load  in  1  observed counter control.
- en  in  1  observed counter control.
- up  in  1  observed counter control.
- d  in  N  observed load data.
- q  in  N  observed counter value.
- max_tick  in  1  observed counter flag.
- min_tick  in  1  observed counter flag.
- err  out  1  one-cycle pulse on any mismatch.
- err_sticky  out  1  set on first mismatch; held until cleared.
- err_cnt  out  CW  saturating mismatch count.
- chk_cnt  out  CW  saturating count of compared cycles.
- first_exp  out  N  expected q at the first error.
- first_act  out  N  actual q at the first error.
- first_kind  out  2  first-error kind: bit0 = q mismatch, bit1 = tick mismatch.
- busy  out  1  1 while in CHECK state.

Behaviour:
- Reset (asynchronous): state=IDLE, ref=0, all outputs 0.
- Next-value function f(c,x), same priority as the counter:
  - syn_clr -> 0
  - else load -> d
  - else en&up -> x+1 mod 2^N
  - else en&~up -> x-1 mod 2^N
  - else x
- Timing: q at edge k reflects the controls sampled at edge k-1. ref always holds the expected current q.
- IDLE:
  - No compare; ref <= f(ctrl,q), resyncing to the observed value.
  - If chk_en=1, go to CHECK.
- CHECK:
  - Each cycle, chk_cnt++ (saturating at 2^CW-1).
  - Mismatch when q!=ref, or max_tick!=(q==2^N-1), or min_tick!=(q==0). Ticks are checked against observed q, so one fault reports as one kind.
  - No mismatch: ref <= f(ctrl,ref), an independent prediction.
  - On mismatch:
    - err=1 for that cycle; err_cnt++ (saturating).
    - If err_sticky=0: capture first_exp=ref, first_act=q, first_kind; set err_sticky. Later errors never overwrite the capture.
    - STOP_ON_ERR=1 -> HALT. STOP_ON_ERR=0 -> stay in CHECK with ref <= f(ctrl,q), so a single fault does not cascade.
  - chk_en=0 -> IDLE, taking priority over the error transition. That cycle's compare is still performed.
- HALT:
  - Counters and captures are frozen; err=0; ref is unchanged.
  - Exit only on clr_stats (-> IDLE) or reset.
- clr_stats (any state):
  - Clears err_sticky, err_cnt, chk_cnt, first_exp, first_act and first_kind.
  - Discards that cycle's compare: no err pulse, no counting.
  - Next state is IDLE; ref <= f(ctrl,q).
- Wrap-around: increment of 2^N-1 gives 0; decrement of 0 gives 2^N-1. Both are arithmetic mod 2^N, with no error.
- Simultaneous controls: resolved only by priority, e.g. syn_clr with load gives 0.
- Reset mid-operation: the checker shares reset with the counter. Both go to 0, and on release the checker is in IDLE, so no spurious error.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'b00, CHECK=2'b01, HALT=2'b10.
  - Error-kind bit positions.
  - Function bin_next(syn_clr, load, en, up, d, x), which the stimulus generator can also reuse.
- One natural sub-module: sat_counter, a CW-bit saturating counter with clear and increment, instantiated twice (err_cnt, chk_cnt).

Test Plan (N=3, CW=8):
- Reset, then chk_en=1; en=1, up=1 for 10 cycles with a correct counter -> q wraps 7->0; err never asserts; err_cnt=0; chk_cnt=10.
- Priority and load: load=1, d=5 with syn_clr=1 -> q=0, no error. Then load=1, d=5 alone -> q=5. Then down-count 5->0->7 -> no error; min_tick at 0, max_tick at 7 accepted.
- Inject q forced to 3 when ref=2 (STOP_ON_ERR=0) -> err pulses for one cycle; err_cnt=1; first_exp=2, first_act=3, first_kind=01. The next correct-relative cycle gives no further error.
- Force max_tick=0 while q=7 -> first_kind=10 (if first error), err_cnt increments, q not flagged.
- STOP_ON_ERR=1, inject one error -> busy falls one cycle later (HALT); further bad q is not counted. clr_stats -> all stats 0, state IDLE; chk_en re-arms checking.
- Assert reset mid-count at q=4 -> counter and checker both at 0; after release, err_sticky=0 and checking resumes without error.
